argmax_topk_stream: RTL and testbench

ARGMAX_TOPK_STREAM -- requirements
Module: argmax_topk_stream

---
 rtl/argmax_topk_stream.sv | 152 +++++++++++++++
 tb/tb_argmax_topk_stream.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_topk_stream.sv
// Streaming top-1/top-2 finder over a frame of signed logits; reports winner, runner-up and margin.
// Result valid 1 clock after the last accepted beat; in_ready drops while a result waits for out_ready.
module argmax_topk_stream #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 54,
    parameter int LANES     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_W-1:0]       data_in,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(N_CLASSES)-1:0]  max_index,
    output logic signed [DATA_W-1:0]      max_value,
    output logic [$clog2(N_CLASSES)-1:0]  second_index,
    output logic [DATA_W:0]               margin,
    output logic                          len_err
);

    localparam int BEATS = N_CLASSES / LANES;
    localparam int IDX_W = $clog2(N_CLASSES);
    localparam int CNT_W = $clog2(BEATS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [DATA_W-1:0] r_v1;
    logic signed [DATA_W-1:0] r_v2;
    logic [IDX_W-1:0]         r_i1;
    logic [IDX_W-1:0]         r_i2;
    logic                     r_have2;
    logic [IDX_W-1:0]         r_sec;
    logic [DATA_W:0]          r_margin;
    logic                     r_len_err;

    logic                     w_xfer;
    logic                     w_start;
    logic                     w_have1;
    logic                     w_have2;
    logic signed [DATA_W-1:0] w_v1;
    logic signed [DATA_W-1:0] w_v2;
    logic [IDX_W-1:0]         w_i1;
    logic [IDX_W-1:0]         w_i2;
    logic signed [DATA_W-1:0] w_lane;
    logic [IDX_W-1:0]         w_idx;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_at_full;
    logic                     w_end;
    logic                     w_len_err;
    logic [IDX_W-1:0]         w_fin_i2;
    logic signed [DATA_W-1:0] w_fin_v2;
    logic [DATA_W:0]          w_margin;

    assign w_xfer = in_valid & in_ready;

    // Lanes are visited in ascending class order, so a strict '>' keeps the lower index on ties.
    always_comb begin
        w_start = (r_state == S_IDLE);
        w_have1 = ~w_start;
        w_have2 = w_start ? 1'b0 : r_have2;
        w_v1    = r_v1;
        w_v2    = r_v2;
        w_i1    = r_i1;
        w_i2    = r_i2;
        w_lane  = '0;
        w_idx   = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane = $signed(data_in[k*DATA_W +: DATA_W]);
            w_idx  = IDX_W'(r_cnt) * IDX_W'(LANES) + IDX_W'(k);
            if (!w_have1 || (w_lane > w_v1)) begin
                w_v2    = w_v1;
                w_i2    = w_i1;
                w_have2 = w_have1;
                w_v1    = w_lane;
                w_i1    = w_idx;
                w_have1 = 1'b1;
            end else if (!w_have2 || (w_lane > w_v2)) begin
                w_v2    = w_lane;
                w_i2    = w_idx;
                w_have2 = 1'b1;
            end
        end
    end

    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_at_full = (w_cnt_nxt == CNT_W'(BEATS));
    assign w_end     = in_last | w_at_full;
    assign w_len_err = ~(in_last & w_at_full);

    // A frame with a single logit has no runner-up: report the winner against itself.
    assign w_fin_i2 = w_have2 ? w_i2 : w_i1;
    assign w_fin_v2 = w_have2 ? w_v2 : w_v1;
    assign w_margin = {w_v1[DATA_W-1], w_v1} - {w_fin_v2[DATA_W-1], w_fin_v2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_v1      <= '0;
            r_v2      <= '0;
            r_i1      <= '0;
            r_i2      <= '0;
            r_have2   <= 1'b0;
            r_sec     <= '0;
            r_margin  <= '0;
            r_len_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_xfer) begin
                        r_v1    <= w_v1;
                        r_v2    <= w_v2;
                        r_i1    <= w_i1;
                        r_i2    <= w_i2;
                        r_have2 <= w_have2;
                        r_cnt   <= w_cnt_nxt;
                        if (w_end) begin
                            r_state   <= S_HOLD;
                            r_sec     <= w_fin_i2;
                            r_margin  <= w_margin;
                            r_len_err <= w_len_err;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = rst_n & (r_state != S_HOLD);
    assign out_valid    = (r_state == S_HOLD);
    assign max_index    = r_i1;
    assign max_value    = r_v1;
    assign second_index = r_sec;
    assign margin       = r_margin;
    assign len_err      = r_len_err;

endmodule

// File: tb/tb_argmax_topk_stream.sv
// Randomized and directed frames checked every cycle against a whole-frame scan model.
module tb_argmax_topk_stream;

    localparam int N     = 10;
    localparam int DW    = 54;
    localparam int L     = 2;
    localparam int BEATS = 5;
    localparam int IW    = 4;
    localparam logic signed [DW-1:0] VMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] VMIN = {1'b1, {(DW-1){1'b0}}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b0;
    logic [L*DW-1:0]   data_in = '0;
    logic              in_ready;
    logic              out_valid;
    logic [IW-1:0]     max_index;
    logic [IW-1:0]     second_index;
    logic signed [DW-1:0] max_value;
    logic [DW:0]       margin;
    logic              len_err;

    argmax_topk_stream #(.N_CLASSES(N), .DATA_W(DW), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .max_index(max_index), .max_value(max_value),
        .second_index(second_index), .margin(margin), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0]        mi;
        logic signed [DW-1:0] mv;
        logic [IW-1:0]        si;
        logic [DW:0]          mg;
        logic                 le;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mode = 2;
    bit   gaps = 0;
    time  first_t;
    time  t0;
    logic signed [DW-1:0] fr[N];
    logic [IW-1:0]        cap_mi, cap_si;
    logic signed [DW-1:0] cap_mv;
    logic [DW:0]          cap_mg;
    logic                 cap_le;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference: scan the received logits as a whole, first maximum wins, then best of the rest.
    function automatic exp_t model(input int nb, input bit use_last);
        exp_t e;
        int n, mx, sc;
        logic signed [DW:0] a, b;
        n  = nb * L;
        mx = 0;
        for (int i = 1; i < n; i++) if (fr[i] > fr[mx]) mx = i;
        if (n == 1) sc = mx;
        else begin
            sc = -1;
            for (int i = 0; i < n; i++)
                if (i != mx && (sc < 0 || fr[i] > fr[sc])) sc = i;
        end
        a = fr[mx];
        b = fr[sc];
        e.mi = IW'(mx);
        e.mv = fr[mx];
        e.si = IW'(sc);
        e.mg = a - b;
        e.le = use_last ? (nb != BEATS) : 1'b1;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = ($urandom_range(0, 3) != 0);
                1: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_max_index", 64'(max_index), 64'(0));
            chk("rst_second_index", 64'(second_index), 64'(0));
            chk("rst_max_value", 64'(max_value), 64'(0));
            chk("rst_margin", 64'(margin), 64'(0));
            chk("rst_len_err", 64'(len_err), 64'(0));
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid));
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: actual out_valid 1 required 0");
                end else begin
                    chk("max_index", 64'(max_index), 64'(q[0].mi));
                    chk("max_value", 64'(max_value), 64'(q[0].mv));
                    chk("second_index", 64'(second_index), 64'(q[0].si));
                    chk("margin", 64'(margin), 64'(q[0].mg));
                    chk("len_err", 64'(len_err), 64'(q[0].le));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic send_frame(input int nb, input bit use_last);
        bit ended;
        bit rdy;
        int t;
        ended = use_last || (nb == BEATS);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_last  = use_last && (b == nb - 1);
            data_in  = {fr[2*b+1], fr[2*b]};
            t = 0;
            forever begin
                rdy = in_ready;
                @(posedge clk);
                if (rdy) break;
                #1;
                t++;
                if (t > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL beat_accept_timeout: actual in_ready 0 required 1");
                    break;
                end
            end
            if (b == 0) first_t = $time;
        end
        if (ended) q.push_back(model(nb, use_last));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("latency_out_valid", 64'(out_valid), 64'(ended));
        cap_mi = max_index;
        cap_si = second_index;
        cap_mv = max_value;
        cap_mg = margin;
        cap_le = len_err;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        q.delete();
        #1;
        chk("rst_immediate", 64'(out_valid), 64'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic load_demo();
        fr = '{54'sd10, 54'sd20, 54'sd5, 54'sd100, 54'sd50,
               54'sd12, 54'sd80, 54'sd45, 54'sd1, 54'sd99};
    endtask

    task automatic load_random();
        logic [63:0] r;
        int s, style;
        style = $urandom_range(0, 2);
        for (int i = 0; i < N; i++) begin
            r = {$urandom(), $urandom()};
            s = int'($urandom_range(0, 6)) - 3;
            case (style)
                0: fr[i] = DW'(s);
                1: fr[i] = r[DW-1:0];
                default: fr[i] = (r[1:0] == 2'd0) ? VMAX : (r[1:0] == 2'd1) ? VMIN : '0;
            endcase
        end
    endtask

    initial begin
        int nb;
        bit ul;
        int t;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        load_demo();
        send_frame(5, 1'b1);
        chk("demo_max_index", 64'(cap_mi), 64'(3));
        chk("demo_max_value", 64'(cap_mv), 64'(100));
        chk("demo_second_index", 64'(cap_si), 64'(9));
        chk("demo_margin", 64'(cap_mg), 64'(1));
        chk("demo_len_err", 64'(cap_le), 64'(0));

        for (int i = 0; i < N; i++) fr[i] = -54'sd1000;
        fr[7] = -54'sd5;
        send_frame(5, 1'b1);
        chk("neg_max_index", 64'(cap_mi), 64'(7));
        chk("neg_second_index", 64'(cap_si), 64'(0));
        chk("neg_margin", 64'(cap_mg), 64'(995));

        for (int i = 0; i < N; i++) fr[i] = 54'sd42;
        send_frame(5, 1'b1);
        chk("tie_max_index", 64'(cap_mi), 64'(0));
        chk("tie_second_index", 64'(cap_si), 64'(1));
        chk("tie_margin", 64'(cap_mg), 64'(0));

        // The zero logits are the runner-up here, so the margin is the max value itself.
        for (int i = 0; i < N; i++) fr[i] = '0;
        fr[4] = VMAX;
        fr[5] = VMIN;
        send_frame(5, 1'b1);
        chk("ext_max_index", 64'(cap_mi), 64'(4));
        chk("ext_margin", 64'(cap_mg), 64'h001F_FFFF_FFFF_FFFF);

        for (int i = 0; i < N; i++) fr[i] = VMIN;
        fr[4] = VMAX;
        send_frame(5, 1'b1);
        chk("span_second_index", 64'(cap_si), 64'(0));
        chk("span_margin", 64'(cap_mg), 64'h003F_FFFF_FFFF_FFFF);

        for (int i = 0; i < N; i++) fr[i] = '0;
        fr[2] = 54'sd7;
        send_frame(3, 1'b1);
        chk("short_max_index", 64'(cap_mi), 64'(2));
        chk("short_margin", 64'(cap_mg), 64'(7));
        chk("short_len_err", 64'(cap_le), 64'(1));
        load_random();
        send_frame(5, 1'b0);
        chk("nolast_len_err", 64'(cap_le), 64'(1));

        load_random();
        send_frame(5, 1'b1);
        t0 = first_t;
        load_random();
        send_frame(5, 1'b1);
        chk("throughput_time", 64'(first_t - t0), 64'(60));

        mode = 1;
        load_demo();
        send_frame(5, 1'b1);
        in_valid = 1'b1;
        data_in  = '1;
        repeat (4) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            chk("hold_out_valid", 64'(out_valid), 64'(1));
            chk("hold_max_index", 64'(max_index), 64'(3));
            chk("hold_max_value", 64'(max_value), 64'(100));
        end
        in_valid = 1'b0;
        mode = 2;

        load_random();
        send_frame(2, 1'b0);
        do_reset();
        load_demo();
        send_frame(5, 1'b1);
        chk("post_rst_max_index", 64'(cap_mi), 64'(3));
        chk("post_rst_second_index", 64'(cap_si), 64'(9));

        mode = 1;
        load_random();
        send_frame(5, 1'b1);
        do_reset();
        @(negedge clk);
        chk("hold_rst_out_valid", 64'(out_valid), 64'(0));

        mode = 0;
        gaps = 1;
        for (int f = 0; f < 60; f++) begin
            nb = $urandom_range(1, BEATS);
            ul = (nb < BEATS) ? 1'b1 : 1'(($urandom_range(0, 1)));
            load_random();
            send_frame(nb, ul);
        end

        mode = 2;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: actual %0d pending results required 0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
